// File: rtl/full_adder_pkg.sv
// Shared arithmetic constants and helpers for the adder family.
// Latency: n/a (elaboration-time only).
// Backpressure: n/a.
package full_adder_pkg;

   // Widest operand the ripple adder is intended to be built at.
   localparam int unsigned FULL_ADDER_MAX_WIDTH = 64;

   // True when a requested operand width lies in the supported range.
   function automatic bit fa_width_ok(input int unsigned width);
      return (width >= 1) && (width <= FULL_ADDER_MAX_WIDTH);
   endfunction

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell: sum and carry-out of a, b and carry-in.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no flow control at this level.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Parity of the three inputs forms the sum bit.
   assign s  = a ^ b ^ ci;
   // Majority of the three inputs forms the carry-out.
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with an optional output register stage.
// Latency: 1 cycle when REGISTERED=1, 0 cycles when REGISTERED=0.
// Backpressure: none; accepts one operation per cycle, out_valid tracks in_valid.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int unsigned WIDTH      = 1,
   parameter bit          REGISTERED = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid
);

   // Refuse to elaborate at widths outside the supported range.
   if (!fa_width_ok(WIDTH)) begin : g_bad_width
      $error("full_adder: WIDTH %0d outside 1..%0d", WIDTH, FULL_ADDER_MAX_WIDTH);
   end

   // Carry rail: bit 0 is the external carry-in, bit WIDTH is the carry-out.
   logic [WIDTH:0]   carry_chain;
   logic [WIDTH-1:0] sum_d;
   logic             carry_d;

   assign carry_chain[0] = c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry_chain[i]),
         .s  (sum_d[i]),
         .co (carry_chain[i+1])
      );
   end

   assign carry_d = carry_chain[WIDTH];

   if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] sum_q;
      logic             carry_q;
      logic             out_valid_q;

      // Result loads every cycle; out_valid alone says whether it is meaningful.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
         end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= in_valid;
         end
      end

      assign sum       = sum_q;
      assign carry     = carry_q;
      assign out_valid = out_valid_q;
   end else begin : g_comb
      // Set on the first clock edge after reset release; holds out_valid low
      // while in reset so the combinational path never reports a result early.
      logic released_q;

      // Tracks whether the block has left reset on a clock edge.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            released_q <= 1'b0;
         end else begin
            released_q <= 1'b1;
         end
      end

      assign sum       = sum_d;
      assign carry     = carry_d;
      assign out_valid = in_valid & released_q;
   end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder across width and register configurations.
// Latency: expectations are popped one cycle after drive for registered DUTs.
// Backpressure: none; inputs are driven every cycle.
module tb_full_adder;

   logic clk;
   logic rst_n;

   // WIDTH=1 stimulus shared by a registered and a combinational instance.
   logic        in_valid1, a1, b1, c1;
   logic        sum1, carry1, ov1;
   logic        sum1c, carry1c, ov1c;

   logic        in_valid8, c8;
   logic [7:0]  a8, b8, sum8;
   logic        carry8, ov8;

   logic        in_valid32, c32;
   logic [31:0] a32, b32, sum32;
   logic        carry32, ov32;

   typedef struct {
      int unsigned w;
      logic        vld;
      logic [32:0] res;
   } sb_t;

   sb_t sb_q[$];

   int passed;
   int total;

   logic [1:0] exp_tab [8];
   logic [7:0] wa [3];
   logic [7:0] wb [3];
   logic       wc [3];
   logic [8:0] wexp [3];

   full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_w1r (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
      .a(a1), .b(b1), .c(c1),
      .sum(sum1), .carry(carry1), .out_valid(ov1)
   );

   full_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_w1c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
      .a(a1), .b(b1), .c(c1),
      .sum(sum1c), .carry(carry1c), .out_valid(ov1c)
   );

   full_adder #(.WIDTH(8), .REGISTERED(1'b1)) u_w8r (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
      .a(a8), .b(b8), .c(c8),
      .sum(sum8), .carry(carry8), .out_valid(ov8)
   );

   full_adder #(.WIDTH(32), .REGISTERED(1'b1)) u_w32r (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32),
      .a(a32), .b(b32), .c(c32),
      .sum(sum32), .carry(carry32), .out_valid(ov32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Pops the oldest expectation and compares it with the DUT of that width.
   task automatic pop_check(input string tag);
      sb_t         e;
      logic        obs_vld;
      logic [32:0] obs_res;
      if (sb_q.size() == 0) begin
         total++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
         return;
      end
      e = sb_q.pop_front();
      case (e.w)
         1:       begin obs_vld = ov1;  obs_res = {31'd0, carry1, sum1};  end
         8:       begin obs_vld = ov8;  obs_res = {24'd0, carry8, sum8};  end
         default: begin obs_vld = ov32; obs_res = {carry32, sum32};       end
      endcase
      chk({tag, "_vld"}, 64'(obs_vld), 64'(e.vld));
      if (e.vld) chk({tag, "_res"}, 64'(obs_res), 64'(e.res));
   endtask

   initial begin
      logic [8:0]  e9;
      logic [32:0] e33;
      passed = 0;
      total  = 0;
      exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      wa   = '{8'hFF, 8'hFF, 8'h7F};
      wb   = '{8'h00, 8'hFF, 8'h01};
      wc   = '{1'b1, 1'b1, 1'b0};
      wexp = '{9'h100, 9'h1FF, 9'h080};

      rst_n = 1'b0;
      in_valid1 = 1'b1; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
      in_valid32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0;

      // Reset state, sampled while clocks run under reset.
      #3;
      chk("rst_sum1", 64'(sum1), 64'(0));
      chk("rst_carry1", 64'(carry1), 64'(0));
      chk("rst_ov1", 64'(ov1), 64'(0));
      chk("rst_ov1c", 64'(ov1c), 64'(0));
      chk("rst_res8", 64'({carry8, sum8}), 64'(0));
      chk("rst_ov8", 64'(ov8), 64'(0));
      chk("rst_res32", 64'({carry32, sum32}), 64'(0));

      // Release between edges: nothing moves until the next rising edge.
      #9;
      rst_n = 1'b1;
      sb_q.push_back('{w: 1, vld: 1'b1, res: 33'd0});
      #1;
      chk("rel_ov1_before_edge", 64'(ov1), 64'(0));
      chk("rel_ov1c_before_edge", 64'(ov1c), 64'(0));
      @(posedge clk); #1;
      pop_check("rel_first");
      chk("rel_ov1c_after_edge", 64'(ov1c), 64'(1));

      // Exhaustive single-bit vectors, registered and combinational.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         {a1, b1, c1} = 3'(i);
         in_valid1 = 1'b1;
         sb_q.push_back('{w: 1, vld: 1'b1, res: 33'(exp_tab[i])});
         #1;
         chk("w1_comb_res", 64'({carry1c, sum1c}), 64'(exp_tab[i]));
         chk("w1_comb_vld", 64'(ov1c), 64'(1));
         @(posedge clk); #1;
         pop_check("w1_reg");
      end
      @(negedge clk);
      in_valid1 = 1'b0;
      #1;
      chk("w1_comb_vld_low", 64'(ov1c), 64'(0));

      // Eight-bit wrap-around corners.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a8 = wa[i]; b8 = wb[i]; c8 = wc[i]; in_valid8 = 1'b1;
         sb_q.push_back('{w: 8, vld: 1'b1, res: 33'(wexp[i])});
         @(posedge clk); #1;
         pop_check("w8_wrap");
      end

      // Alternating valid with random operands.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
         in_valid8 = (k % 2 == 0);
         e9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
         sb_q.push_back('{w: 8, vld: in_valid8, res: 33'(e9)});
         @(posedge clk); #1;
         pop_check("w8_gate");
      end
      @(negedge clk);
      in_valid8 = 1'b0;

      // Reset asserted mid-stream, between edges.
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; in_valid1 = 1'b1;
      sb_q.push_back('{w: 1, vld: 1'b1, res: 33'd3});
      @(posedge clk); #1;
      pop_check("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sum1", 64'(sum1), 64'(0));
      chk("mid_rst_carry1", 64'(carry1), 64'(0));
      chk("mid_rst_ov1", 64'(ov1), 64'(0));
      chk("mid_rst_ov1c", 64'(ov1c), 64'(0));
      chk("mid_rst_res8", 64'({carry8, sum8}), 64'(0));
      in_valid1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ov1_pre_edge", 64'(ov1), 64'(0));
      @(posedge clk); #1;
      chk("post_rst_ov1_edge1", 64'(ov1), 64'(0));
      chk("post_rst_sum1_edge1", 64'(sum1), 64'(1));
      chk("post_rst_carry1_edge1", 64'(carry1), 64'(1));
      @(posedge clk); #1;
      chk("post_rst_ov1_edge2", 64'(ov1), 64'(0));

      // Random regression at 32 bits, back to back.
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         a32 = $urandom; b32 = $urandom; c32 = 1'($urandom_range(0, 1));
         in_valid32 = 1'b1;
         e33 = {1'b0, a32} + {1'b0, b32} + {32'd0, c32};
         sb_q.push_back('{w: 32, vld: 1'b1, res: e33});
         @(posedge clk); #1;
         pop_check("w32_rnd");
      end
      @(negedge clk);
      in_valid32 = 1'b0;
      @(posedge clk); #1;
      chk("w32_vld_drop", 64'(ov32), 64'(0));
      chk("sb_empty", 64'(sb_q.size()), 64'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_full_adder
